// File: rtl/raw_pattern_gen.sv
// Raw Bayer (RGGB) test-pattern source with programmable frame timing.
// Drives the 8-bit single-channel stream that isp_top consumes, so every
// ISP stage can be exercised with known, repeatable content.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | counters held at 0, stream outputs low, waiting for enable
// S_RUN  | scanning frames; enable and pattern_mode re-sampled at frame end
module raw_pattern_gen #(
   parameter int source_h    = 1024,
   parameter int source_v    = 1024,
   parameter int H_BLANK     = 64,
   parameter int V_BLANK     = 8,
   parameter int VSYNC_LINES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [2:0]  pattern_mode,
   output logic        out_vsync,
   output logic        out_hsync,
   output logic        out_den,
   output logic [7:0]  out_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = source_h + H_BLANK;
   localparam int V_TOTAL = V_BLANK + source_v;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = source_h / 8;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic [2:0]      mode_q, mode_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            done_pend_q, done_pend_d;
   logic            frame_done_q, frame_done_d;
   logic            vsync_q, vsync_d;
   logic            hsync_q, hsync_d;
   logic [7:0]      data_q, data_d;

   logic            h_last;
   logic            v_last;
   logic            active;
   logic [7:0]      x8;
   logic [7:0]      y8;
   logic [2:0]      bar;
   logic [2:0]      bar_rgb;
   logic            site_bit;
   logic            lfsr_fb;
   logic [15:0]     lfsr_nxt;
   logic [7:0]      pix;

   // Pixel coordinates, Bayer site colour and the selected pattern sample.
   always_comb begin
      h_last   = (h_cnt_q == HW'(H_TOTAL - 1));
      v_last   = (v_cnt_q == VW'(V_TOTAL - 1));
      active   = (v_cnt_q >= VW'(V_BLANK)) && (h_cnt_q < HW'(source_h));
      x8       = 8'(h_cnt_q);
      // Only the low byte of y is ever needed, so subtract in 8 bits.
      y8       = 8'(v_cnt_q) - 8'(V_BLANK);
      bar      = 3'(h_cnt_q / HW'(BAR_W));
      lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_nxt = {lfsr_fb, lfsr_q[15:1]};

      case (bar)
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase

      // {y[0], x[0]}: 00 = R, 01/10 = G, 11 = B.
      case ({y8[0], x8[0]})
         2'b00:   site_bit = bar_rgb[2];
         2'b11:   site_bit = bar_rgb[0];
         default: site_bit = bar_rgb[1];
      endcase

      case (mode_q)
         3'd0:    pix = 8'h80;
         3'd1:    pix = x8;
         3'd2:    pix = y8;
         3'd3:    pix = site_bit ? 8'hFF : 8'h00;
         3'd4:    pix = (x8[4] ^ y8[4]) ? 8'hE0 : 8'h20;
         3'd5:    pix = x8 + frame_cnt_q[7:0];
         3'd6: begin
            if ((x8[5:0] == 6'd32) && (y8[5:0] == 6'd32))
               pix = 8'hFF;
            else if ((x8[5:0] == 6'd0) && (y8[5:0] == 6'd0))
               pix = 8'h00;
            else
               pix = 8'h40;
         end
         default: pix = lfsr_nxt[7:0];
      endcase
   end

   // Next-state, counter sequencing and registered-output inputs.
   always_comb begin
      state_d      = state_q;
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;
      mode_d       = mode_q;
      lfsr_d       = lfsr_q;
      done_pend_d  = 1'b0;
      // The frame-done pulse trails the final blank output cycle by one.
      frame_done_d = done_pend_q;
      frame_cnt_d  = frame_cnt_q + 16'(done_pend_q);
      vsync_d      = 1'b0;
      hsync_d      = 1'b0;
      data_d       = 8'h00;

      case (state_q)
         S_IDLE: begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            lfsr_d  = LFSR_SEED;
            if (enable) begin
               mode_d  = pattern_mode;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            vsync_d = (v_cnt_q < VW'(VSYNC_LINES));
            hsync_d = active;
            if (active) begin
               data_d = pix;
               lfsr_d = lfsr_nxt;
            end
            if (h_last) begin
               h_cnt_d = '0;
               if (v_last) begin
                  // The last cycle is always blank, so the reseed never
                  // collides with an active-pixel shift.
                  v_cnt_d     = '0;
                  lfsr_d      = LFSR_SEED;
                  done_pend_d = 1'b1;
                  if (enable)
                     mode_d = pattern_mode;
                  else
                     state_d = S_IDLE;
               end else begin
                  v_cnt_d = v_cnt_q + VW'(1);
               end
            end else begin
               h_cnt_d = h_cnt_q + HW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         mode_q       <= 3'd0;
         lfsr_q       <= LFSR_SEED;
         frame_cnt_q  <= 16'd0;
         done_pend_q  <= 1'b0;
         frame_done_q <= 1'b0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         data_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         mode_q       <= mode_d;
         lfsr_q       <= lfsr_d;
         frame_cnt_q  <= frame_cnt_d;
         done_pend_q  <= done_pend_d;
         frame_done_q <= frame_done_d;
         vsync_q      <= vsync_d;
         hsync_q      <= hsync_d;
         data_q       <= data_d;
      end
   end

   assign out_vsync  = vsync_q;
   assign out_hsync  = hsync_q;
   assign out_den    = hsync_q;
   assign out_data   = data_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
